// File: rtl/um_counter.sv
// 8-bit up/down counter for the TinyTapeout user-module harness. It has enable,
// direction, clear, load, wrap/saturate and a /1,/2,/4,/16 prescaler.
module um_counter (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [7:0] count;
  logic [3:0] pcnt;

  logic       c_en, c_dir, c_load, c_clr, c_sat, c_oe;
  logic [1:0] c_presc;
  logic [3:0] presc_mask;
  logic       step;
  logic [7:0] count_next;

  assign c_en    = ui_in[0];
  assign c_dir   = ui_in[1];
  assign c_load  = ui_in[2];
  assign c_clr   = ui_in[3];
  assign c_sat   = ui_in[4];
  assign c_presc = ui_in[6:5];
  assign c_oe    = ui_in[7];

  // Step fires when the low N bits of pcnt are all ones. N=0 gives an empty mask,
  // so every enabled cycle steps.
  always_comb begin
    presc_mask = '0;
    case (c_presc)
      2'b00:   presc_mask = 4'b0000;
      2'b01:   presc_mask = 4'b0001;
      2'b10:   presc_mask = 4'b0011;
      default: presc_mask = 4'b1111;
    endcase
  end

  assign step = ((pcnt & presc_mask) == presc_mask);

  always_comb begin
    count_next = count;
    if (c_dir) begin
      if (count == 8'h00) count_next = c_sat ? 8'h00 : 8'hFF;
      else                count_next = count - 8'd1;
    end else begin
      if (count == 8'hFF) count_next = c_sat ? 8'hFF : 8'h00;
      else                count_next = count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      pcnt  <= '0;
    end else if (ena) begin
      if (c_clr) begin
        count <= '0;
        pcnt  <= '0;
      end else if (c_load) begin
        count <= uio_in;
        pcnt  <= '0;
      end else if (c_en) begin
        pcnt <= pcnt + 4'd1;
        if (step) count <= count_next;
      end
    end
  end

  assign uo_out  = count;
  assign uio_out = c_oe ? count : '0;
  assign uio_oe  = c_oe ? '1 : '0;

endmodule

// File: tb/tb_um_counter.sv
// Directed bench for um_counter. A behavioural model is checked on every cycle,
// and hand-computed literal expectations pin down the model.
module tb_um_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  int m_count = 0;
  int m_pcnt  = 0;

  um_counter dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  // Model of the counter rules, written with plain integer arithmetic.
  always @(posedge clk) begin
    int div;
    bit stp;
    if (!rst_n) begin
      m_count = 0;
      m_pcnt  = 0;
    end else if (ena) begin
      if (ui_in[3]) begin
        m_count = 0;
        m_pcnt  = 0;
      end else if (ui_in[2]) begin
        m_count = int'(uio_in);
        m_pcnt  = 0;
      end else if (ui_in[0]) begin
        div = (ui_in[6:5] == 2'd3) ? 16 : (1 << ui_in[6:5]);
        stp = ((m_pcnt % div) == div - 1);
        m_pcnt = (m_pcnt + 1) % 16;
        if (stp) begin
          if (ui_in[1]) m_count = ui_in[4] ? ((m_count > 0) ? m_count - 1 : 0)
                                           : (m_count + 255) % 256;
          else          m_count = ui_in[4] ? ((m_count < 255) ? m_count + 1 : 255)
                                           : (m_count + 1) % 256;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_cnt, e_out, e_oe;
    if (checking) begin
      e_cnt = 8'(m_count);
      e_out = ui_in[7] ? e_cnt : 8'h00;
      e_oe  = ui_in[7] ? 8'hFF : 8'h00;
      n_cmp++;
      if (uo_out !== e_cnt || uio_out !== e_out || uio_oe !== e_oe) begin
        n_err++;
        $display("FAIL model t=%0t: uo_out=%h uio_out=%h uio_oe=%h, want %h %h %h",
                 $time, uo_out, uio_out, uio_oe, e_cnt, e_out, e_oe);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    ui_in  = 8'h04;
    uio_in = v;
    cyc(1);
  endtask

  initial begin
    // Reset with all controls asserted
    rst_n = 1'b0; ui_in = 8'hFF; uio_in = 8'h55;
    cyc(1);
    checking = 1'b1;
    cyc(1);
    chk("reset", uo_out, 8'h00);
    chk("reset_oe_comb", uio_oe, 8'hFF);
    chk("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1; ui_in = 8'h01;
    cyc(5);
    chk("count_up_5", uo_out, 8'h05);

    // Load, then count down with wrap
    load(8'h02);
    chk("load_02", uo_out, 8'h02);
    ui_in = 8'h03;
    cyc(1); chk("down_1", uo_out, 8'h01);
    cyc(1); chk("down_0", uo_out, 8'h00);
    cyc(1); chk("down_wrap", uo_out, 8'hFF);
    cyc(1); chk("down_FE", uo_out, 8'hFE);

    // Saturate at the top, then at the bottom
    load(8'hFD);
    ui_in = 8'h11;
    cyc(1); chk("sat_up_FE", uo_out, 8'hFE);
    cyc(1); chk("sat_up_FF", uo_out, 8'hFF);
    cyc(3); chk("sat_up_hold", uo_out, 8'hFF);
    load(8'h01);
    ui_in = 8'h13;
    cyc(1); chk("sat_dn_00", uo_out, 8'h00);
    cyc(2); chk("sat_dn_hold", uo_out, 8'h00);

    // Prescaler /4 and /16 from a clear
    ui_in = 8'h08; cyc(1);
    ui_in = 8'h41;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk($sformatf("presc4_c%0d", i), uo_out, 8'(i / 4));
    end
    ui_in = 8'h08; cyc(1);
    ui_in = 8'h61;
    cyc(15); chk("presc16_c15", uo_out, 8'h00);
    cyc(1);  chk("presc16_c16", uo_out, 8'h01);
    cyc(16); chk("presc16_c32", uo_out, 8'h02);

    // Switching PRESC keeps pcnt: /2 for 3 cycles, then /4 steps at once
    ui_in = 8'h08; cyc(1);
    ui_in = 8'h21; cyc(3); chk("presc2_c3", uo_out, 8'h01);
    ui_in = 8'h41; cyc(1); chk("presc_switch", uo_out, 8'h02);

    // CLR beats LOAD; ena gating; EN=0 hold
    ui_in = 8'h0C; uio_in = 8'hAA; cyc(1);
    chk("clr_over_load", uo_out, 8'h00);
    load(8'h37);
    ena = 1'b0; ui_in = 8'h01;
    cyc(10); chk("ena0_hold", uo_out, 8'h37);
    ui_in = 8'h0C; uio_in = 8'h99;
    cyc(2); chk("ena0_no_clr", uo_out, 8'h37);
    ena = 1'b1; ui_in = 8'h00;
    cyc(3); chk("en0_hold", uo_out, 8'h37);

    // Output enable
    load(8'h5A);
    ui_in = 8'h80; #1;
    chk("oe1_uio_oe", uio_oe, 8'hFF);
    chk("oe1_uio_out", uio_out, 8'h5A);
    cyc(1);
    ui_in = 8'h00; #1;
    chk("oe0_uio_oe", uio_oe, 8'h00);
    chk("oe0_uio_out", uio_out, 8'h00);
    ui_in = 8'h84; uio_in = 8'h33; cyc(1);
    chk("load_with_oe", uo_out, 8'h33);
    chk("load_with_oe_pin", uio_out, 8'h33);
    ui_in = 8'h00; cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
